menu_text_arb: RTL

MENU_TEXT_ARB -- requirements
Module: menu_text_arb

---
 rtl/menu_text_arb.sv | 73 +++++++
 1 files changed

// File: rtl/menu_text_arb.sv
// Two-requester arbiter in front of a shared character-code ROM.
// Grants one address per cycle and returns the ROM code, tagged with its owner, two cycles later.
module menu_text_arb #(
    parameter int PRIO_FIXED = 0,
    parameter int MAX_WAIT   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [7:0] xy0,
    input  logic [7:0] xy1,
    output logic [1:0] gnt,
    output logic [7:0] rom_xy,
    input  logic [6:0] rom_code,
    output logic [6:0] char_code,
    output logic [1:0] rsp_vld
);

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    logic       last_gnt;   // 1: requester 1 was granted most recently
    logic [7:0] wait_cnt;
    logic [1:0] tag_s1;

    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    if (PRIO_FIXED != 0)
                        gnt = (wait_cnt == WAIT_LIM) ? 2'b10 : 2'b01;
                    else
                        gnt = last_gnt ? 2'b01 : 2'b10;
                end
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt  <= 1'b1;
            wait_cnt  <= 8'h00;
            rom_xy    <= 8'h00;
            tag_s1    <= 2'b00;
            rsp_vld   <= 2'b00;
            char_code <= 7'h00;
        end else begin
            if (gnt != 2'b00) begin
                last_gnt <= gnt[1];
                rom_xy   <= gnt[1] ? xy1 : xy0;
            end

            // stage 1 tracks the address on rom_xy, stage 2 the code captured from the ROM
            tag_s1  <= gnt;
            rsp_vld <= tag_s1;
            if (tag_s1 != 2'b00)
                char_code <= rom_code;

            if (PRIO_FIXED != 0) begin
                if (!req[1] || gnt[1])
                    wait_cnt <= 8'h00;
                else if (wait_cnt != WAIT_LIM)
                    wait_cnt <= wait_cnt + 8'h01;
            end else begin
                wait_cnt <= 8'h00;
            end
        end
    end

endmodule
